// File: rtl/mjp_match_ctrl.sv
// Match-level sequencer for the muk-jji-ppa game core: arms the core per game,
// tallies results and declares a first-to-WIN_TARGET winner or a draw-limit tie.
module mjp_match_ctrl #(
    parameter int WIN_TARGET = 3,
    parameter int MAX_DRAWS  = 7,
    parameter int HOLD_CYC   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [1:0] AIN,
    input  logic [1:0] BIN,
    input  logic       RES_VALID,
    input  logic [1:0] RES_CODE,
    output logic       CORE_EN,
    output logic       CORE_CLR,
    output logic [3:0] A_SCORE,
    output logic [3:0] B_SCORE,
    output logic [3:0] DRAWS,
    output logic       MATCH_DONE,
    output logic [1:0] MATCH_WINNER,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_CLEAR  = 3'b001,
        ST_SETTLE = 3'b010,
        ST_PLAY   = 3'b011,
        ST_DONE   = 3'b100
    } state_t;

    localparam logic [3:0] WIN_T  = 4'(WIN_TARGET);
    localparam logic [3:0] DRAW_T = 4'(MAX_DRAWS);
    localparam logic [7:0] HOLD_T = 8'(HOLD_CYC);

    state_t     state;
    logic [7:0] hold_cnt;
    logic [3:0] a_new, b_new, d_new;
    logic       both_invalid, result_ok;

    assign STATE = state;

    always_comb begin
        a_new        = A_SCORE + {3'b000, RES_CODE == 2'b00};
        b_new        = B_SCORE + {3'b000, RES_CODE == 2'b01};
        d_new        = DRAWS   + {3'b000, RES_CODE == 2'b10};
        both_invalid = (AIN == 2'b11) && (BIN == 2'b11);
        result_ok    = RES_VALID && (RES_CODE != 2'b11);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            hold_cnt     <= 8'd0;
            CORE_EN      <= 1'b0;
            CORE_CLR     <= 1'b0;
            A_SCORE      <= 4'd0;
            B_SCORE      <= 4'd0;
            DRAWS        <= 4'd0;
            MATCH_DONE   <= 1'b0;
            MATCH_WINNER <= 2'b00;
        end else begin
            CORE_CLR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state        <= ST_CLEAR;
                        CORE_CLR     <= 1'b1;
                        A_SCORE      <= 4'd0;
                        B_SCORE      <= 4'd0;
                        DRAWS        <= 4'd0;
                        MATCH_WINNER <= 2'b00;
                    end
                end
                ST_CLEAR: state <= ST_SETTLE;
                ST_SETTLE: begin
                    // Arm only after both players show INVALID, so a held gesture never starts a game.
                    if (both_invalid) begin
                        state   <= ST_PLAY;
                        CORE_EN <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (result_ok) begin
                        A_SCORE <= a_new;
                        B_SCORE <= b_new;
                        DRAWS   <= d_new;
                        CORE_EN <= 1'b0;
                        if (a_new == WIN_T || b_new == WIN_T || d_new == DRAW_T) begin
                            state      <= ST_DONE;
                            MATCH_DONE <= 1'b1;
                            hold_cnt   <= 8'd0;
                            if (a_new == WIN_T)      MATCH_WINNER <= 2'b01;
                            else if (b_new == WIN_T) MATCH_WINNER <= 2'b10;
                            else                     MATCH_WINNER <= 2'b11;
                        end else begin
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (START && hold_cnt == HOLD_T) begin
                        state        <= ST_CLEAR;
                        CORE_CLR     <= 1'b1;
                        MATCH_DONE   <= 1'b0;
                        A_SCORE      <= 4'd0;
                        B_SCORE      <= 4'd0;
                        DRAWS        <= 4'd0;
                        MATCH_WINNER <= 2'b00;
                    end else if (hold_cnt < HOLD_T) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mjp_match_ctrl.sv
// Bench for mjp_match_ctrl: directed match scenarios plus random traffic,
// every cycle compared against a rule-level match model.
module tb_mjp_match_ctrl;

    localparam int WIN_TARGET = 3;
    localparam int MAX_DRAWS  = 7;
    localparam int HOLD_CYC   = 4;

    logic       CLK, RST, START, RES_VALID;
    logic [1:0] AIN, BIN, RES_CODE;
    logic       CORE_EN, CORE_CLR, MATCH_DONE;
    logic [3:0] A_SCORE, B_SCORE, DRAWS;
    logic [1:0] MATCH_WINNER;
    logic [2:0] STATE;

    int checks   = 0;
    int failures = 0;

    logic [19:0] exp_q[$];

    mjp_match_ctrl #(
        .WIN_TARGET(WIN_TARGET), .MAX_DRAWS(MAX_DRAWS), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .AIN(AIN), .BIN(BIN),
        .RES_VALID(RES_VALID), .RES_CODE(RES_CODE),
        .CORE_EN(CORE_EN), .CORE_CLR(CORE_CLR),
        .A_SCORE(A_SCORE), .B_SCORE(B_SCORE), .DRAWS(DRAWS),
        .MATCH_DONE(MATCH_DONE), .MATCH_WINNER(MATCH_WINNER), .STATE(STATE)
    );

    // clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Match model: phase of the match plus tallies, in spec terms.
    localparam int P_IDLE = 0, P_CLEAR = 1, P_SETTLE = 2, P_PLAY = 3, P_DONE = 4;
    int m_phase = P_IDLE;
    int m_a = 0, m_b = 0, m_d = 0, m_win = 0, m_done_cycles = 0;

    function automatic void new_match();
        m_phase = P_CLEAR;
        m_a = 0; m_b = 0; m_d = 0; m_win = 0;
    endfunction

    function automatic void model_step(input bit rst, input bit start, input int ain, input int bin,
                                       input bit rv, input int code);
        if (rst) begin
            m_phase = P_IDLE;
            m_a = 0; m_b = 0; m_d = 0; m_win = 0; m_done_cycles = 0;
            return;
        end
        case (m_phase)
            P_IDLE:   if (start) new_match();
            P_CLEAR:  m_phase = P_SETTLE;
            P_SETTLE: if (ain == 3 && bin == 3) m_phase = P_PLAY;
            P_PLAY: begin
                if (rv && code != 3) begin
                    if (code == 0) m_a++;
                    if (code == 1) m_b++;
                    if (code == 2) m_d++;
                    if (m_a == WIN_TARGET || m_b == WIN_TARGET || m_d == MAX_DRAWS) begin
                        m_win = (m_a == WIN_TARGET) ? 1 : (m_b == WIN_TARGET) ? 2 : 3;
                        m_phase = P_DONE;
                        m_done_cycles = 0;
                    end else begin
                        m_phase = P_SETTLE;
                    end
                end
            end
            P_DONE: begin
                if (start && m_done_cycles >= HOLD_CYC) new_match();
                else m_done_cycles++;
            end
            default: m_phase = P_IDLE;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // driver: apply one cycle of inputs, advance the model, compare at the negedge
    task automatic step(input bit rst, input bit st, input logic [1:0] a, input logic [1:0] b,
                        input bit rv, input logic [1:0] code);
        logic [19:0] e;
        RST = rst; START = st; AIN = a; BIN = b; RES_VALID = rv; RES_CODE = code;
        @(posedge CLK);
        model_step(rst, st, int'(a), int'(b), rv, int'(code));
        exp_q.push_back({3'(m_phase), m_phase == P_PLAY, m_phase == P_CLEAR,
                         4'(m_a), 4'(m_b), 4'(m_d), m_phase == P_DONE, 2'(m_win)});
        @(negedge CLK);
        e = exp_q.pop_front();
        check("state",      32'(STATE),        32'(e[19:17]));
        check("core_en",    32'(CORE_EN),      32'(e[16]));
        check("core_clr",   32'(CORE_CLR),     32'(e[15]));
        check("a_score",    32'(A_SCORE),      32'(e[14:11]));
        check("b_score",    32'(B_SCORE),      32'(e[10:7]));
        check("draws",      32'(DRAWS),        32'(e[6:3]));
        check("match_done", 32'(MATCH_DONE),   32'(e[2]));
        check("winner",     32'(MATCH_WINNER), 32'(e[1:0]));
    endtask

    task automatic idle_cycle();
        step(0, 0, 2'b00, 2'b00, 0, 2'b00);
    endtask

    task automatic play_game(input logic [1:0] code);
        step(0, 0, 2'b11, 2'b11, 0, 2'b00);
        step(0, 0, 2'b00, 2'b01, 1, code);
    endtask

    task automatic begin_match();
        step(0, 1, 2'b00, 2'b00, 0, 2'b00);
        idle_cycle();
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; AIN = 2'b00; BIN = 2'b00; RES_VALID = 1'b0; RES_CODE = 2'b00;
        @(negedge CLK);

        step(1, 0, 2'b00, 2'b00, 0, 2'b00);
        step(1, 1, 2'b11, 2'b11, 1, 2'b00);
        // result strobe in IDLE is ignored
        step(0, 0, 2'b11, 2'b11, 1, 2'b00);

        // A wins 3-0 with arming gate and ignored events
        begin_match();
        for (int i = 0; i < 5; i++) step(0, 0, 2'b00, 2'b01, 1, 2'b01);
        check("gate_state", 32'(STATE), 32'd2);
        step(0, 0, 2'b11, 2'b11, 0, 2'b00);
        check("armed_state", 32'(STATE), 32'd3);
        step(0, 0, 2'b00, 2'b00, 1, 2'b11);
        step(0, 1, 2'b00, 2'b00, 0, 2'b00);
        play_game(2'b00);
        check("a_after_1", 32'(A_SCORE), 32'd1);
        play_game(2'b00);
        step(0, 1, 2'b11, 2'b11, 0, 2'b00);
        step(0, 1, 2'b00, 2'b00, 1, 2'b00);
        check("a_win_winner", 32'(MATCH_WINNER), 32'd1);
        check("a_win_en", 32'(CORE_EN), 32'd0);

        // hold lockout: START every cycle, accepted only once the hold expires
        for (int i = 0; i < HOLD_CYC; i++) step(0, 1, 2'b00, 2'b00, 0, 2'b00);
        check("hold_locked", 32'(STATE), 32'd4);
        step(0, 1, 2'b00, 2'b00, 0, 2'b00);
        check("restart_clr", 32'(CORE_CLR), 32'd1);
        idle_cycle();
        check("clr_one_cycle", 32'(CORE_CLR), 32'd0);

        // draw-limit tie
        for (int i = 0; i < MAX_DRAWS; i++) play_game(2'b10);
        check("tie_winner", 32'(MATCH_WINNER), 32'd3);
        check("tie_draws", 32'(DRAWS), 32'(MAX_DRAWS));

        // reset mid-match at A=2, B=1 while in PLAY
        step(1, 0, 2'b00, 2'b00, 0, 2'b00);
        begin_match();
        play_game(2'b00);
        play_game(2'b01);
        play_game(2'b00);
        step(0, 0, 2'b11, 2'b11, 0, 2'b00);
        step(1, 0, 2'b11, 2'b11, 1, 2'b00);
        check("rst_mid_state", 32'(STATE), 32'd0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bit r_rst, r_st, r_rv;
            logic [1:0] r_a, r_b, r_code;
            r_rst  = ($urandom_range(0, 299) == 0);
            r_st   = ($urandom_range(0, 5) == 0);
            r_rv   = ($urandom_range(0, 2) == 0);
            r_a    = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 3));
            r_b    = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 3));
            r_code = 2'($urandom_range(0, 3));
            step(r_rst, r_st, r_a, r_b, r_rv, r_code);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
